// File: rtl/cpu_reg_package.sv
// Shared CPU register-bus definitions for the UART transmitter.
// Contents: bus widths, UART register offsets, the STATUS register
// layout and the TX state encoding.
package cpu_reg_package;

   localparam int address_width = 32;
   localparam int data_width    = 32;

   localparam logic [address_width-1:0] UART_TXDATA_OFS = 32'h0000_0000;
   localparam logic [address_width-1:0] UART_STATUS_OFS = 32'h0000_0004;
   localparam logic [address_width-1:0] UART_CTRL_OFS   = 32'h0000_0008;

   // STATUS register as seen on the bus, MSB first.
   typedef struct packed {
      logic [22:0] rsvd;
      logic [4:0]  count;
      logic        ovf;
      logic        busy;
      logic        empty;
      logic        full;
   } uart_status_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/bus_uart_tx_if.sv
// CPU bus connection of the UART transmitter.
// Signal names are from the peripheral's point of view:
//   address_i  bus address          (master -> slave)
//   we_i       write strobe         (master -> slave)
//   data_i     write data           (master -> slave)
//   data_o     registered read data (slave -> master)
//   irq_o      level interrupt      (slave -> master)
interface bus_uart_tx_if;
   import cpu_reg_package::*;

   logic [address_width-1:0] address_i;
   logic                     we_i;
   logic [data_width-1:0]    data_i;
   logic [data_width-1:0]    data_o;
   logic                     irq_o;

   modport master (
      output address_i,
      output we_i,
      output data_i,
      input  data_o,
      input  irq_o
   );

   modport slave (
      input  address_i,
      input  we_i,
      input  data_i,
      output data_o,
      output irq_o
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word read-through.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   push_i/data_i   write request and data; ignored when full, even if a
//                   pop happens in the same cycle
//   pop_i/data_o    read request; data_o always shows the oldest entry
//   full_o/empty_o  derived from a separate occupancy counter
//   count_o         occupancy 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; the pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter (8N1) with a TX FIFO.
// Registers (offsets from BASE_ADDR):
//   +0 TXDATA  write only, pushes data[7:0]
//   +4 STATUS  read only: full, empty, busy, ovf (sticky, cleared on read), count
//   +8 CTRL    bit0 irq_en
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   bus             CPU bus slave (address, write strobe/data, read data, irq)
//   uart_tx_o       serial line, idle high, driven from a flop
//
// state    | meaning
// ---------+-----------------------------------------------
// TX_IDLE  | line high, waiting for the FIFO to hold a byte
// TX_START | start bit (0) for CLKS_PER_BIT cycles
// TX_DATA  | 8 data bits, LSB first, CLKS_PER_BIT each
// TX_STOP  | stop bit (1); at its end pop next byte or idle
module bus_uart_tx import cpu_reg_package::*; #(
   parameter logic [address_width-1:0] BASE_ADDR    = 32'h0000_9000,
   parameter int                       CLKS_PER_BIT = 868,
   parameter int                       FIFO_DEPTH   = 16
) (
   input  logic          clk_i,
   input  logic          reset_i,
   bus_uart_tx_if.slave  bus,
   output logic          uart_tx_o
);

   localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam int                CNT_W       = $clog2(FIFO_DEPTH + 1);

   // Reset asserts immediately but is released only after two clk_i edges,
   // so every flop leaves reset on a clean clock boundary.
   logic [1:0] rst_sync_q;
   logic       rst_int;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) rst_sync_q <= 2'b11;
      else         rst_sync_q <= {rst_sync_q[0], 1'b0};
   end

   assign rst_int = rst_sync_q[1];

   logic sel_txdata;
   logic sel_status;
   logic sel_ctrl;
   logic push_req;
   logic status_rd;
   logic ctrl_wr;

   assign sel_txdata = (bus.address_i == BASE_ADDR + UART_TXDATA_OFS);
   assign sel_status = (bus.address_i == BASE_ADDR + UART_STATUS_OFS);
   assign sel_ctrl   = (bus.address_i == BASE_ADDR + UART_CTRL_OFS);
   assign push_req   = bus.we_i & sel_txdata;
   assign status_rd  = ~bus.we_i & sel_status;
   assign ctrl_wr    = bus.we_i & sel_ctrl;

   logic             unused_data;
   assign unused_data = &{1'b0, bus.data_i[data_width-1:8]};

   tx_state_t        state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shreg_q;
   logic             tx_q;

   logic [7:0]       fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_pop;

   // Pops only look at the registered empty flag, so a byte pushed into an
   // empty FIFO is taken one cycle later.
   assign fifo_pop = ~fifo_empty &
                     ((state_q == TX_IDLE) || ((state_q == TX_STOP) && (baud_q == '0)));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (rst_int),
      .push_i  (push_req),
      .data_i  (bus.data_i[7:0]),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_ff @(posedge clk_i or posedge rst_int) begin
      if (rst_int) begin
         state_q   <= TX_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            TX_IDLE: begin
               if (!fifo_empty) begin
                  shreg_q <= fifo_rdata;
                  baud_q  <= BAUD_RELOAD;
                  tx_q    <= 1'b0;
                  state_q <= TX_START;
               end
            end
            TX_START: begin
               if (baud_q == '0) begin
                  baud_q    <= BAUD_RELOAD;
                  bit_idx_q <= 3'd0;
                  tx_q      <= shreg_q[0];
                  state_q   <= TX_DATA;
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            TX_DATA: begin
               if (baud_q == '0) begin
                  baud_q <= BAUD_RELOAD;
                  if (bit_idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= TX_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= shreg_q[bit_idx_q + 3'd1];
                  end
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            TX_STOP: begin
               if (baud_q == '0) begin
                  if (!fifo_empty) begin
                     shreg_q <= fifo_rdata;
                     baud_q  <= BAUD_RELOAD;
                     tx_q    <= 1'b0;
                     state_q <= TX_START;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= TX_IDLE;
            end
         endcase
      end
   end

   assign uart_tx_o = tx_q;

   logic                  irq_en_q;
   logic                  ovf_q;
   logic                  irq_q;
   logic [data_width-1:0] rdata_q;
   logic [data_width-1:0] rdata_d;
   uart_status_t          status_d;

   always_comb begin
      status_d       = '0;
      status_d.full  = fifo_full;
      status_d.empty = fifo_empty;
      status_d.busy  = (state_q != TX_IDLE);
      status_d.ovf   = ovf_q;
      status_d.count = 5'(fifo_count);
   end

   always_comb begin
      rdata_d = '0;
      if (!bus.we_i) begin
         if (sel_status)    rdata_d = status_d;
         else if (sel_ctrl) rdata_d = {{(data_width-1){1'b0}}, irq_en_q};
      end
   end

   always_ff @(posedge clk_i or posedge rst_int) begin
      if (rst_int) begin
         rdata_q  <= '0;
         irq_en_q <= 1'b0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         if (ctrl_wr) irq_en_q <= bus.data_i[0];
         // A new overflow wins over the clear-on-read in the same cycle.
         if (push_req && fifo_full) ovf_q <= 1'b1;
         else if (status_rd)        ovf_q <= 1'b0;
         irq_q <= irq_en_q & fifo_empty & (state_q == TX_IDLE);
      end
   end

   assign bus.data_o = rdata_q;
   assign bus.irq_o  = irq_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=16).
// A line monitor decodes every frame into bytes; the expected byte stream
// is the list of pushes the FIFO should have accepted.
module tb_bus_uart_tx;
   import cpu_reg_package::*;

   localparam logic [31:0] BASE   = 32'h0000_9000;
   localparam int          CPB    = 4;
   localparam int          DEPTH  = 16;
   localparam logic [31:0] A_TX   = BASE + 32'h0;
   localparam logic [31:0] A_ST   = BASE + 32'h4;
   localparam logic [31:0] A_CTRL = BASE + 32'h8;
   localparam logic [31:0] A_UNM  = BASE + 32'hC;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic uart_tx;

   bus_uart_tx_if bus_if ();

   bus_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk_i     (clk),
      .reset_i   (rst),
      .bus       (bus_if),
      .uart_tx_o (uart_tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   bit mon_en = 1'b0;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   function automatic logic [31:0] status_word(input int full, input int empty,
                                               input int busy, input int ovf, input int count);
      return 32'(count * 16 + ovf * 8 + busy * 4 + empty * 2 + full);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus_if.we_i      = 1'b0;
      bus_if.address_i = '0;
      bus_if.data_i    = '0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus_if.address_i = a;
      bus_if.we_i      = 1'b1;
      bus_if.data_i    = d;
      tick();
      bus_idle();
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus_if.address_i = a;
      bus_if.we_i      = 1'b0;
      tick();
      d = bus_if.data_o;
      bus_idle();
   endtask

   task automatic tx_write(input logic [7:0] b, input bit accept);
      bus_write(A_TX, {24'h5A5A5A, b});
      if (accept) exp_q.push_back(b);
   endtask

   task automatic wait_drain(input string name);
      logic [31:0] s;
      bit done;
      done = 1'b0;
      s    = '0;
      for (int n = 0; n < 3000 && !done; n++) begin
         bus_read(A_ST, s);
         if (s[2:1] == 2'b01) done = 1'b1;
      end
      chk({name, "_drain"}, {31'b0, done}, 32'd1);
   endtask

   task automatic compare_rx(input string name);
      chk({name, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; rx_q.size() > 0 && exp_q.size() > 0; i++) begin
         logic [7:0] r;
         logic [7:0] e;
         r = rx_q.pop_front();
         e = exp_q.pop_front();
         chk($sformatf("%s_byte%0d", name, i), {24'b0, r}, {24'b0, e});
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   // Line monitor: on a falling edge, sample mid-bit for start, 8 data bits
   // and stop, then record the byte.
   initial begin : monitor
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && uart_tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            chk("mon_start_bit", {31'b0, uart_tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            chk("mon_stop_bit", {31'b0, uart_tx}, 32'd1);
            rx_q.push_back(b);
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] rd;
      logic [7:0]  b;
      logic [9:0]  frame;
      vec_t        vecs[12];
      int          n;
      int          bad;

      bus_idle();
      #2 rst = 1'b1;
      #1;
      chk("reset_line_high", {31'b0, uart_tx}, 32'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) tick();
      chk("reset_data_o", bus_if.data_o, 32'd0);
      chk("reset_irq", {31'b0, bus_if.irq_o}, 32'd0);
      chk("reset_line_idle", {31'b0, uart_tx}, 32'd1);
      mon_en = 1'b1;

      // Register map vectors
      vecs[0]  = '{0, A_ST,   32'h0,         status_word(0, 1, 0, 0, 0), "status_reset"};
      vecs[1]  = '{0, A_CTRL, 32'h0,         32'h0, "ctrl_reset"};
      vecs[2]  = '{1, A_CTRL, 32'h1,         32'h0, "ctrl_wr1"};
      vecs[3]  = '{0, A_CTRL, 32'h0,         32'h1, "ctrl_rd1"};
      vecs[4]  = '{1, A_CTRL, 32'hFFFF_FFFE, 32'h0, "ctrl_wr_even"};
      vecs[5]  = '{0, A_CTRL, 32'h0,         32'h0, "ctrl_rd_even"};
      vecs[6]  = '{1, A_ST,   32'hFFFF_FFFF, 32'h0, "status_wr"};
      vecs[7]  = '{0, A_ST,   32'h0,         status_word(0, 1, 0, 0, 0), "status_after_wr"};
      vecs[8]  = '{0, A_UNM,  32'h0,         32'h0, "unmapped_rd"};
      vecs[9]  = '{0, A_TX,   32'h0,         32'h0, "txdata_rd"};
      vecs[10] = '{1, A_CTRL, 32'h3,         32'h0, "ctrl_wr3"};
      vecs[11] = '{0, A_CTRL, 32'h0,         32'h1, "ctrl_rd3"};
      foreach (vecs[i]) begin
         if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
         else begin
            bus_read(vecs[i].addr, rd);
            chk(vecs[i].name, rd, vecs[i].exp);
         end
      end
      chk("irq_idle_enabled", {31'b0, bus_if.irq_o}, 32'd1);
      tick();
      chk("data_o_idle_zero", bus_if.data_o, 32'd0);
      bus_write(A_CTRL, 32'h0);
      tick();
      tick();
      chk("irq_disabled", {31'b0, bus_if.irq_o}, 32'd0);

      // Single 0x55 frame, cycle by cycle, STATUS held on the bus
      b = 8'h55;
      frame = {1'b1, b, 1'b0};
      tx_write(b, 1'b1);
      bus_if.address_i = A_ST;
      for (int k = 0; k < 10 * CPB; k++) begin
         tick();
         chk($sformatf("frame55_c%0d", k), {31'b0, uart_tx}, {31'b0, frame[k / CPB]});
         if (k == 20) chk("busy_mid_frame", {31'b0, bus_if.data_o[2]}, 32'd1);
      end
      tick();
      chk("frame55_end_line", {31'b0, uart_tx}, 32'd1);
      chk("busy_last_stop", {31'b0, bus_if.data_o[2]}, 32'd1);
      tick();
      chk("busy_after_frame", {31'b0, bus_if.data_o[2]}, 32'd0);
      bus_idle();
      wait_drain("frame55");
      compare_rx("frame55");

      // Overflow: FSM busy, 17 back-to-back pushes, no pop during the burst
      tx_write(8'h3C, 1'b1);
      tick();
      tick();
      for (int i = 0; i < DEPTH + 1; i++) tx_write(8'($urandom), i < DEPTH);
      bus_read(A_ST, rd);
      chk("ovf_status_first", rd, status_word(1, 0, 1, 1, DEPTH));
      bus_read(A_ST, rd);
      chk("ovf_status_second", rd, status_word(1, 0, 1, 0, DEPTH));
      wait_drain("ovf");
      compare_rx("ovf");

      // Interrupt on drain
      bus_write(A_CTRL, 32'h1);
      tick();
      chk("irq_before_push", {31'b0, bus_if.irq_o}, 32'd1);
      tx_write(8'h81, 1'b1);
      tx_write(8'h7E, 1'b1);
      chk("irq_low_after_push", {31'b0, bus_if.irq_o}, 32'd0);
      n = 0;
      while (bus_if.irq_o !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      chk("irq_latency", n, 2 * 10 * CPB + 1);
      chk("irq_rx_count", rx_q.size(), 2);
      tx_write(8'hF0, 1'b1);
      tick();
      chk("irq_clear_on_write", {31'b0, bus_if.irq_o}, 32'd0);
      wait_drain("irq");
      compare_rx("irq");
      bus_write(A_CTRL, 32'h0);

      // Reset 10 clocks into a frame with 3 bytes queued
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) tx_write(8'h00, 1'b0);
      repeat (8) tick();
      chk("line_low_before_reset", {31'b0, uart_tx}, 32'd0);
      rst = 1'b1;
      #1;
      chk("reset_midframe_line", {31'b0, uart_tx}, 32'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) tick();
      bus_read(A_ST, rd);
      chk("status_after_midframe_reset", rd, status_word(0, 1, 0, 0, 0));
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (uart_tx !== 1'b1) bad++;
      end
      chk("no_toggle_after_reset", bad, 0);
      mon_en = 1'b1;

      // Push during the final STOP clock with an empty FIFO
      tx_write(8'hC3, 1'b1);
      repeat (10 * CPB) tick();
      chk("stop_last_clock_line", {31'b0, uart_tx}, 32'd1);
      tx_write(8'hA7, 1'b1);
      chk("gap_cycle_line", {31'b0, uart_tx}, 32'd1);
      tick();
      chk("late_start_line", {31'b0, uart_tx}, 32'd0);
      wait_drain("late_push");
      compare_rx("late_push");

      // Random bursts with random gaps, never more than the FIFO holds
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            tx_write(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
         end
         wait_drain($sformatf("rand%0d", r));
         compare_rx($sformatf("rand%0d", r));
         bus_read(A_ST, rd);
         chk($sformatf("rand%0d_status", r), rd, status_word(0, 1, 0, 0, 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
